// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receive types and defaults
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DEFAULT_PRESCALE   = 8;
  localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - line synchronizer and 3-point mid-bit majority sampler
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE,
  parameter int CW       = $clog2(PRESCALE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_rx,
  input  logic [CW-1:0] i_edge_cnt,
  output logic          o_rx_s,
  output logic          o_sampled_bit,
  output logic          o_sample_pt
);

  localparam logic [CW-1:0] C_S0 = CW'(PRESCALE / 2 - 1);
  localparam logic [CW-1:0] C_S1 = CW'(PRESCALE / 2);
  localparam logic [CW-1:0] C_S2 = CW'(PRESCALE / 2 + 1);

  logic r_sync1;
  logic r_sync2;
  logic r_s0;
  logic r_s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_s0    <= 1'b1;
      r_s1    <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      if (i_edge_cnt == C_S0) r_s0 <= r_sync2;
      if (i_edge_cnt == C_S1) r_s1 <= r_sync2;
    end
  end

  // Third sample is the live synchronized line so the decision lands on C_S2 itself.
  assign o_rx_s        = r_sync2;
  assign o_sample_pt   = (i_edge_cnt == C_S2);
  assign o_sampled_bit = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);

endmodule

// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - UART receive FSM: start detect, LSB-first shift, parity and stop checks
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int Data_Width = DEFAULT_DATA_WIDTH,
  parameter int PRESCALE   = DEFAULT_PRESCALE
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [Data_Width-1:0] P_Data,
  output logic                  Data_Valid,
  output logic                  Par_Err,
  output logic                  Stp_Err
);

  localparam int CW = $clog2(PRESCALE);
  localparam int BW = (Data_Width > 1) ? $clog2(Data_Width) : 1;
  localparam logic [CW-1:0] C_LAST     = CW'(PRESCALE - 1);
  localparam logic [BW-1:0] C_LAST_BIT = BW'(Data_Width - 1);

  uart_state_t           r_state;
  uart_state_t           w_next_state;
  logic [CW-1:0]         r_edge_cnt;
  logic [BW-1:0]         r_bit_cnt;
  logic [Data_Width-1:0] r_shift;
  logic [Data_Width-1:0] r_p_data;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_par_bad;
  logic                  r_valid;
  logic                  r_par_err;
  logic                  r_stp_err;

  logic w_rx_s;
  logic w_bit;
  logic w_sample_pt;
  logic w_bit_end;
  logic w_last_bit;
  logic w_par_exp;
  logic w_start;
  logic w_shift_en;
  logic w_par_chk;
  logic w_frame_done;
  logic w_bit_adv;

  uart_rx_sampler #(
    .PRESCALE(PRESCALE),
    .CW      (CW)
  ) u_sampler (
    .clk          (clk),
    .rst          (RST),
    .i_rx         (RX_IN),
    .i_edge_cnt   (r_edge_cnt),
    .o_rx_s       (w_rx_s),
    .o_sampled_bit(w_bit),
    .o_sample_pt  (w_sample_pt)
  );

  assign w_bit_end  = (r_edge_cnt == C_LAST);
  assign w_last_bit = (r_bit_cnt == C_LAST_BIT);
  assign w_par_exp  = (r_par_typ == PAR_ODD) ? ~^r_shift : ^r_shift;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (!w_rx_s) w_next_state = START;
      START: begin
        if (w_sample_pt && w_bit) w_next_state = IDLE;
        else if (w_bit_end)       w_next_state = DATA;
      end
      DATA:    if (w_bit_end && w_last_bit) w_next_state = r_par_en ? PARITY : STOP;
      PARITY:  if (w_bit_end) w_next_state = STOP;
      // Leave at mid-bit so a back-to-back start edge is never missed.
      STOP:    if (w_sample_pt) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_start      = 1'b0;
    w_shift_en   = 1'b0;
    w_par_chk    = 1'b0;
    w_frame_done = 1'b0;
    w_bit_adv    = 1'b0;
    case (r_state)
      IDLE:    w_start      = ~w_rx_s;
      DATA: begin
        w_shift_en = w_sample_pt;
        w_bit_adv  = w_bit_end & ~w_last_bit;
      end
      PARITY:  w_par_chk    = w_sample_pt;
      STOP:    w_frame_done = w_sample_pt;
      default: w_start      = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_par_bad  <= 1'b0;
    end else begin
      if (r_state == IDLE || w_next_state == IDLE || w_bit_end) r_edge_cnt <= '0;
      else                                                      r_edge_cnt <= r_edge_cnt + CW'(1);

      if (r_state == IDLE) r_bit_cnt <= '0;
      else if (w_bit_adv)  r_bit_cnt <= r_bit_cnt + BW'(1);

      if (w_shift_en) r_shift <= {w_bit, r_shift[Data_Width-1:1]};

      if (w_start) begin
        r_par_en  <= PAR_EN;
        r_par_typ <= PAR_TYP;
        r_par_bad <= 1'b0;
      end else if (w_par_chk) begin
        r_par_bad <= (w_bit != w_par_exp);
      end
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_p_data  <= '0;
      r_valid   <= 1'b0;
      r_par_err <= 1'b0;
      r_stp_err <= 1'b0;
    end else begin
      r_valid   <= w_frame_done & w_bit & ~r_par_bad;
      r_par_err <= w_frame_done & r_par_bad;
      r_stp_err <= w_frame_done & ~w_bit;
      if (w_frame_done && w_bit && !r_par_bad) r_p_data <= r_shift;
    end
  end

  assign P_Data     = r_p_data;
  assign Data_Valid = r_valid;
  assign Par_Err    = r_par_err;
  assign Stp_Err    = r_stp_err;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb/tb_uart_rx_deserializer.sv - self-checking bench for uart_rx_deserializer
module tb_uart_rx_deserializer;

  localparam int P  = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          RST;
  logic          RX_IN;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic [DW-1:0] P_Data;
  logic          Data_Valid;
  logic          Par_Err;
  logic          Stp_Err;

  int            cyc = 0;
  int            n_tests = 0;
  int            n_fail = 0;
  int            t_start = 0;
  logic [DW-1:0] model_pdata = '0;

  uart_rx_deserializer #(
    .Data_Width(DW),
    .PRESCALE  (P)
  ) dut (
    .clk       (clk),
    .RST       (RST),
    .RX_IN     (RX_IN),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .P_Data    (P_Data),
    .Data_Valid(Data_Valid),
    .Par_Err   (Par_Err),
    .Stp_Err   (Stp_Err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic          v;
    logic          pe;
    logic          se;
    logic [DW-1:0] d;
  } evt_t;
  evt_t evq[$];

  always @(negedge clk)
    if (Data_Valid || Par_Err || Stp_Err)
      evq.push_back('{cyc, Data_Valid, Par_Err, Stp_Err, P_Data});

  typedef struct {
    logic [DW-1:0] d;
    logic          pe;
    logic          typ;
    logic          parbit;
    logic          stop;
    logic          ev;
    logic          epe;
    logic          ese;
    logic [DW-1:0] ed;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic drive_bit(input logic b, input logic spike);
    RX_IN = b;
    if (spike) begin
      repeat (4) @(posedge clk);
      #1 RX_IN = ~b;
      @(posedge clk);
      #1 RX_IN = b;
      repeat (P - 5) @(posedge clk);
      #1;
    end else begin
      repeat (P) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic pe, input logic typ,
                            input logic parbit, input logic stop, input int gap_bits,
                            input int spike_bit);
    PAR_EN  = pe;
    PAR_TYP = typ;
    t_start = cyc;
    drive_bit(1'b0, 1'b0);
    PAR_EN  = 1'($urandom);
    PAR_TYP = 1'($urandom);
    for (int i = 0; i < DW; i++) drive_bit(d[i], i == spike_bit);
    if (pe) drive_bit(parbit, 1'b0);
    drive_bit(stop, 1'b0);
    for (int i = 0; i < gap_bits; i++) drive_bit(1'b1, 1'b0);
  endtask

  task automatic check_frame(input string tag, input logic ev, input logic epe, input logic ese,
                             input logic [DW-1:0] ed, input logic pe);
    evt_t e;
    int   lat;
    int   l_min;
    chk({tag, " pulse_count"}, evq.size(), 1);
    if (evq.size() > 0) begin
      e = evq.pop_front();
      chk({tag, " Data_Valid"}, e.v, ev);
      chk({tag, " Par_Err"}, e.pe, epe);
      chk({tag, " Stp_Err"}, e.se, ese);
      chk({tag, " P_Data_at_pulse"}, e.d, ed);
      lat   = e.cyc - t_start;
      l_min = 2 + P * (1 + DW + (pe ? 1 : 0)) + P / 2 + 2;
      n_tests++;
      if (lat < l_min || lat > l_min + 2) begin
        n_fail++;
        $display("FAIL %s latency: got %0d cycles, expected %0d..%0d", tag, lat, l_min, l_min + 2);
      end
    end
    evq.delete();
    chk({tag, " P_Data_hold"}, P_Data, ed);
    model_pdata = ed;
  endtask

  // Parity bit that makes the total count of ones even (typ=0) or odd (typ=1).
  function automatic logic good_parity(input logic [DW-1:0] d, input logic typ);
    return ((($countones(d) % 2) == 1) ? 1'b1 : 1'b0) ^ typ;
  endfunction

  initial begin
    logic [DW-1:0] d;
    logic          pe, typ, parbit, stop, par_bad, ev;
    evt_t          e0, e1;

    tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
    tbl[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C};
    tbl[2] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C};
    tbl[3] = '{8'h81, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h81};
    tbl[4] = '{8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h81};
    tbl[5] = '{8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h81};

    RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("reset P_Data", P_Data, 0);
    chk("reset Data_Valid", Data_Valid, 0);
    chk("reset Par_Err", Par_Err, 0);
    chk("reset Stp_Err", Stp_Err, 0);
    @(posedge clk);
    #1 RST = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].d, tbl[i].pe, tbl[i].typ, tbl[i].parbit, tbl[i].stop, 2, -1);
      check_frame($sformatf("vec%0d", i), tbl[i].ev, tbl[i].epe, tbl[i].ese, tbl[i].ed, tbl[i].pe);
    end

    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 2, 3);
    check_frame("spike", 1'b1, 1'b0, 1'b0, 8'h55, 1'b0);

    RX_IN = 1'b0;
    repeat (2) @(posedge clk);
    #1 RX_IN = 1'b1;
    repeat (3 * P) @(posedge clk);
    #1;
    chk("glitch pulse_count", evq.size(), 0);
    chk("glitch P_Data", P_Data, model_pdata);
    evq.delete();

    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 0, -1);
    send_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 2, -1);
    chk("b2b pulse_count", evq.size(), 2);
    if (evq.size() == 2) begin
      e0 = evq.pop_front();
      e1 = evq.pop_front();
      chk("b2b first data", e0.d, 8'h55);
      chk("b2b first valid", e0.v, 1);
      chk("b2b second data", e1.d, 8'hAA);
      chk("b2b second valid", e1.v, 1);
      chk("b2b spacing", e1.cyc - e0.cyc, P * (DW + 2));
    end
    evq.delete();
    model_pdata = 8'hAA;

    PAR_EN = 1'b0;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1 RST = 1'b1;
    @(negedge clk);
    chk("midreset P_Data", P_Data, 0);
    chk("midreset Data_Valid", Data_Valid, 0);
    chk("midreset Par_Err", Par_Err, 0);
    chk("midreset Stp_Err", Stp_Err, 0);
    repeat (3) @(posedge clk);
    #1 RST = 1'b0;
    repeat (3 * P) @(posedge clk);
    #1;
    chk("midreset pulse_count", evq.size(), 0);
    evq.delete();
    model_pdata = '0;
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 2, -1);
    check_frame("after_reset", 1'b1, 1'b0, 1'b0, 8'h12, 1'b0);

    for (int n = 0; n < 24; n++) begin
      d       = DW'($urandom);
      pe      = 1'($urandom);
      typ     = 1'($urandom);
      parbit  = good_parity(d, typ) ^ ($urandom_range(0, 3) == 0);
      stop    = ($urandom_range(0, 4) != 0);
      par_bad = pe && ((($countones(d) + (parbit ? 1 : 0)) % 2) != (typ ? 1 : 0));
      ev      = stop && !par_bad;
      send_frame(d, pe, typ, parbit, stop, 2, -1);
      check_frame($sformatf("rand%0d", n), ev, par_bad, ~stop, ev ? d : model_pdata, pe);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
